led_matrix_column_scanner: RTL and testbench

//  Time-multiplexed driver for the 5x7 LED matrix. Consumes the 7-bit row images produced by the
//  per-column status decoders and scans them onto the physical matrix one column at a time.
//  A dead-time gap between columns suppresses ghosting. Frame data is double-buffered so a frame
//  is never torn. Sits between the decoder bank and the matrix pins.

---
 rtl/led_matrix_column_scanner.sv | 133 +++++++++++++
 tb/tb_led_matrix_column_scanner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_column_scanner.sv
// Column scanner for the 5x7 status matrix.
// Double-buffered frame, dead-time between columns, registered outputs.
module led_matrix_column_scanner #(
    parameter int COLS        = 5,
    parameter int ROWS        = 7,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [COLS*ROWS-1:0]   frame_data,
    output logic [COLS-1:0]        col_sel,
    output logic [ROWS-1:0]        row_out,
    output logic                   frame_start
);

    // One counter times both phases, so it must hold the longer one.
    localparam int PMAX = (CLK_DIV > DEAD_CYCLES) ? CLK_DIV : DEAD_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [PW-1:0] DRIVE_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] DEAD_LAST  =
        PW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam bit            HAS_DEAD   = (DEAD_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [PW-1:0]          pre, pre_n;
    logic [CW-1:0]          idx, idx_n;
    logic [COLS*ROWS-1:0]   shadow, shadow_n;
    logic                   load;
    logic [COLS-1:0]        col_n;
    logic [ROWS-1:0]        row_n;
    state_t                 gap_state;

    assign gap_state = HAS_DEAD ? DEAD : DRIVE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pre    <= '0;
            idx    <= '0;
            shadow <= '0;
        end else begin
            state  <= state_n;
            pre    <= pre_n;
            idx    <= idx_n;
            shadow <= shadow_n;
        end
    end

    always_comb begin
        state_n = state;
        pre_n   = pre;
        idx_n   = idx;
        load    = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            pre_n   = '0;
            idx_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    load    = 1'b1;
                    idx_n   = '0;
                    pre_n   = '0;
                    state_n = gap_state;
                end
                DEAD: begin
                    if (pre == DEAD_LAST) begin
                        pre_n   = '0;
                        state_n = DRIVE;
                    end else begin
                        pre_n = pre + 1'b1;
                    end
                end
                DRIVE: begin
                    if (pre == DRIVE_LAST) begin
                        pre_n   = '0;
                        state_n = gap_state;
                        // Last column: wrap and swap in the next frame.
                        if (idx == COL_LAST) begin
                            idx_n = '0;
                            load  = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        pre_n = pre + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    pre_n   = '0;
                    idx_n   = '0;
                end
            endcase
        end
    end

    assign shadow_n = load ? frame_data : shadow;

    // Outputs are decoded from the next state so they can be registered.
    always_comb begin
        col_n = '1;
        row_n = '0;
        if (state_n == DRIVE) begin
            col_n[idx_n] = 1'b0;
            row_n        = shadow_n[int'(idx_n)*ROWS +: ROWS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_sel     <= '1;
            row_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            col_sel     <= col_n;
            row_out     <= row_n;
            frame_start <= load;
        end
    end

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// Scoreboard bench for led_matrix_column_scanner.
// Two instances: DEAD_CYCLES=1 and DEAD_CYCLES=0, same stimulus.
module tb_led_matrix_column_scanner;

    localparam int COLS    = 5;
    localparam int ROWS    = 7;
    localparam int CLK_DIV = 4;
    localparam logic [12:0] OFF = {5'b11111, 7'h00, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [34:0] frame_data;
    logic [4:0]  cs1, cs0;
    logic [6:0]  ro1, ro0;
    logic        fs1, fs0;

    int passed = 0;
    int total  = 0;

    logic [12:0] q1[$];
    logic [12:0] q0[$];
    bit          run[2];
    int          jj[2];
    logic [34:0] fr[2];
    int          cur_col = -1;

    always #5 clk = ~clk;

    led_matrix_column_scanner #(
        .COLS(COLS), .ROWS(ROWS), .CLK_DIV(CLK_DIV), .DEAD_CYCLES(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .frame_data(frame_data),
        .col_sel(cs1), .row_out(ro1), .frame_start(fs1)
    );

    led_matrix_column_scanner #(
        .COLS(COLS), .ROWS(ROWS), .CLK_DIV(CLK_DIV), .DEAD_CYCLES(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .frame_data(frame_data),
        .col_sel(cs0), .row_out(ro0), .frame_start(fs0)
    );

    // Expected outputs j cycles after a frame load, from slot arithmetic.
    function automatic logic [12:0] expect_at(int j, int dead,
                                              logic [34:0] frm);
        int slot;
        int f;
        int c;
        int o;
        logic [4:0] cs;
        logic [6:0] r;
        slot = CLK_DIV + dead;
        f    = j % (COLS * slot);
        c    = f / slot;
        o    = f % slot;
        cs   = 5'b11111;
        r    = 7'h00;
        if (o >= dead) begin
            cs[c] = 1'b0;
            r     = frm[c*ROWS +: ROWS];
        end
        return {cs, r, (f == 0)};
    endfunction

    function automatic logic [34:0] rand35();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[34:0];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int dead;
            logic [12:0] e;
            dead = (i == 0) ? 1 : 0;
            if (!rst_n || !enable) begin
                run[i] = 1'b0;
                e = OFF;
            end else begin
                if (!run[i]) begin
                    run[i] = 1'b1;
                    jj[i]  = 0;
                end else begin
                    jj[i]++;
                end
                if (jj[i] % (COLS * (CLK_DIV + dead)) == 0)
                    fr[i] = frame_data;
                e = expect_at(jj[i], dead, fr[i]);
            end
            if (i == 0) begin
                q1.push_back(e);
                cur_col = -1;
                for (int c = 0; c < COLS; c++)
                    if (e[8+c] == 1'b0) cur_col = c;
            end else begin
                q0.push_back(e);
            end
        end
    end

    task automatic check(input string name, input logic [12:0] act,
                         input logic [12:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s t=%0t got cs=%b row=%h fs=%b want cs=%b row=%h fs=%b",
                      name, $time, act[12:8], act[7:1], act[0],
                      exp[12:8], exp[7:1], exp[0]);
    endtask

    task automatic check_inv(input string name, input logic [4:0] cs,
                             input logic [6:0] ro);
        total++;
        if ($countones(~cs) <= 1 && (cs != 5'b11111 || ro == 7'h00))
            passed++;
        else $display("FAIL %s t=%0t cs=%b row=%h violates one-hot/blank",
                      name, $time, cs, ro);
    endtask

    always @(negedge clk) begin
        if (q1.size() > 0) check("scan_d1", {cs1, ro1, fs1}, q1.pop_front());
        if (q0.size() > 0) check("scan_d0", {cs0, ro0, fs0}, q0.pop_front());
        check_inv("inv_d1", cs1, ro1);
        check_inv("inv_d0", cs0, ro0);
    end

    task automatic wait_col(input int c);
        int n;
        n = 0;
        while (cur_col != c && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (cur_col != c) begin
            total++;
            $display("FAIL wait_col%0d timed out, model col=%0d", c, cur_col);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        frame_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < COLS; c++)
            frame_data[c*ROWS +: ROWS] = 7'h01 << c;
        @(negedge clk);
        enable = 1'b1;
        repeat (30) @(negedge clk);

        wait_col(2);
        frame_data = '1;
        repeat (40) @(negedge clk);

        wait_col(3);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        frame_data = rand35();
        enable = 1'b1;
        repeat (30) @(negedge clk);

        wait_col(1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_d1", {cs1, ro1, fs1}, OFF);
        check("async_rst_d0", {cs0, ro0, fs0}, OFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        repeat (400) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) frame_data = rand35();
            if (enable && $urandom_range(0, 49) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
        end
        enable = 1'b1;
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
